dmem_responder: RTL



---
 rtl/dmem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store port for the RV32I core's data memory.
// Optional per-byte store strobes are enabled by defining DMEM_BYTE_EN (adds input wstrb).
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  wstrb,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        misaligned
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_mis;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_take;
  logic            w_commit;
  logic            w_c_we;
  logic            w_c_mis;
  logic [AW-1:0]   w_c_idx;
  logic [31:0]     w_c_wdata;
  logic [3:0]      w_c_strb;
  logic            w_unused_addr;

  assign w_unused_addr = ^addr[31:AW+2];

  assign w_take = (r_state == IDLE) && req;

  // With LATENCY=0 the commit edge is also the acceptance edge, so the access
  // must come straight from the ports rather than the (not yet loaded) latches.
  assign w_c_we    = w_take ? MemWrite          : r_we;
  assign w_c_mis   = w_take ? (addr[1:0] != '0) : r_mis;
  assign w_c_idx   = w_take ? addr[AW+1:2]      : r_idx;
  assign w_c_wdata = w_take ? wdata             : r_wdata;

`ifdef DMEM_BYTE_EN
  logic [3:0] r_wstrb;
  assign w_c_strb = w_take ? wstrb : r_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstrb <= '0;
    end else if (w_take) begin
      r_wstrb <= wstrb;
    end
  end
`else
  assign w_c_strb = '1;
`endif

  assign w_commit = (w_next == RESP) && (r_state != RESP);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign stall      = ((r_state == IDLE) && req) || (r_state == WAIT);
  assign ready      = (r_state == RESP);
  assign misaligned = (r_state == RESP) && r_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_cnt   <= 4'(LATENCY);
        r_we    <= MemWrite;
        r_mis   <= (addr[1:0] != '0);
        r_idx   <= addr[AW+1:2];
        r_wdata <= wdata;
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !w_c_we) begin
        rdata <= w_c_mis ? '0 : r_mem[w_c_idx];
      end
    end
  end

  // Array is not reset; rst_n only blocks a commit while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_c_we && !w_c_mis) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_c_strb[b]) begin
          r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
